// File: rtl/serial_loader_if.sv
// serial_loader_if: groups the word handshake and the serial output strobes
// of serial_loader.
//   din        parallel word offered to the loader
//   din_valid  din holds a word to transfer
//   din_ready  loader can take a word (hold register empty)
//   d          serial data bit
//   d_en       one-cycle sample strobe for the downstream shift register
//   busy       a word is being shifted
//   done       pulse on the last d_en of each word
// master: the side that offers words and watches the serial stream.
// slave:  the loader itself.
interface serial_loader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             d;
    logic             d_en;
    logic             busy;
    logic             done;

    modport master (
        output din, din_valid,
        input  din_ready, d, d_en, busy, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, d, d_en, busy, done
    );
endinterface

// File: rtl/serial_loader.sv
// serial_loader: parallel-to-serial front end for an 8-bit serial-in shift
// register. Words arrive over a valid/ready handshake; one word shifts while
// a second may wait in the hold register. Each bit is held on d for
// CLKS_PER_BIT clocks, with d_en high in the last clock of the bit period.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    serial_loader_if slave modport (din/din_valid/din_ready,
//          d/d_en/busy/done)
module serial_loader #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int MSB_FIRST    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_loader_if.slave        bus
);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shifter_q, shifter_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic              accept;
    logic              div_last;
    logic              bit_last;
    logic              boundary;
    logic [WIDTH-1:0]  shifted;

    assign accept   = bus.din_valid && !hold_full_q;
    assign div_last = (div_cnt_q == DIV_W'(CLKS_PER_BIT - 1));
    assign bit_last = (bit_cnt_q == BIT_W'(WIDTH - 1));
    assign boundary = (state_q == SHIFT) && div_last && bit_last;
    assign shifted  = (MSB_FIRST != 0) ? {shifter_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shifter_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (boundary && !hold_full_q && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy      = (state_q == SHIFT);
        bus.d_en      = (state_q == SHIFT) && div_last;
        bus.done      = (state_q == SHIFT) && div_last && bit_last;
        bus.din_ready = !hold_full_q;
        bus.d         = 1'b0;
        if (state_q == SHIFT) begin
            bus.d = (MSB_FIRST != 0) ? shifter_q[WIDTH-1] : shifter_q[0];
        end
    end

    // Datapath next values. An accept outside a boundary always lands in
    // hold: din_ready guarantees hold is empty whenever accept is possible.
    always_comb begin
        shifter_d   = shifter_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        if (state_q == IDLE) begin
            if (accept) shifter_d = bus.din;
        end else if (boundary) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            if (hold_full_q) begin
                shifter_d   = hold_q;
                hold_full_d = 1'b0;
            end else if (accept) begin
                shifter_d = bus.din;
            end else begin
                shifter_d = shifted;
            end
        end else begin
            if (accept) begin
                hold_d      = bus.din;
                hold_full_d = 1'b1;
            end
            if (div_last) begin
                div_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                shifter_d = shifted;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shifter_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            shifter_q   <= shifter_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end
endmodule

// File: doc/serial_loader.md
# serial_loader

Parallel-to-serial front end that feeds the 8-bit serial-in `shift_register`. It accepts parallel words over a valid/ready handshake and buffers one word behind the one in flight. Each word is driven out bit by bit on `d`, with each bit held for a programmable number of clocks. A one-cycle `d_en` strobe per bit tells the downstream shift register when to sample. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `CLKS_PER_BIT`, 4: clocks each bit is held on `d`; must be ≥ 1.
- `MSB_FIRST`, 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `din`  in  WIDTH  parallel word; sampled on the accepting edge.
- `din_valid`  in  1  `din` holds a word to transfer.
- `din_ready`  out  1  block can take a word; combinational `!hold_full`.
- `d`  out  1  serial data to the downstream `d` input.
- `d_en`  out  1  one-cycle strobe; downstream samples `d` when high.
- `busy`  out  1  a word is being shifted (state SHIFT).
- `done`  out  1  one-cycle pulse on the last `d_en` of each word.

## Operation
- Storage elements:
  - `shifter` (WIDTH bits);
  - `hold` (WIDTH bits) with flag `hold_full`;
  - `div_cnt` (counts 0..CLKS_PER_BIT-1);
  - `bit_cnt` (counts 0..WIDTH-1);
  - state register.
- States:
  - IDLE: nothing to send.
  - SHIFT: a word is in `shifter`.
- Accept: a transfer occurs on an edge where `din_valid && din_ready`.
- Destination of an accepted word:
  - Goes straight into `shifter` if state is IDLE.
  - Also goes straight into `shifter` at a word boundary with `hold_full`=0.
  - Otherwise goes into `hold` and sets `hold_full`.
- Word boundary: the cycle where `div_cnt==CLKS_PER_BIT-1` and `bit_cnt==WIDTH-1` in SHIFT. At its edge:
  - If `hold_full`: `shifter` ← `hold`, clear `hold_full`, stay in SHIFT.
  - Else if an accept occurs: `shifter` ← `din`, stay in SHIFT.
  - Else: go to IDLE.
  - In all cases `div_cnt` and `bit_cnt` return to 0.
- Transitions:
  - IDLE→SHIFT on accept.
  - SHIFT→SHIFT at a boundary when a word is available.
  - SHIFT→IDLE at a boundary otherwise.
- Bit advance: in SHIFT, `div_cnt` increments every cycle. When it reaches `CLKS_PER_BIT-1` it wraps to 0, `bit_cnt` increments and `shifter` shifts one place (direction per `MSB_FIRST`, 0 filled).
- `d` = current output bit of `shifter` (MSB or LSB) in SHIFT; 0 in IDLE.
- `d_en` = (state==SHIFT) && `div_cnt==CLKS_PER_BIT-1`.
- `done` = `d_en` && `bit_cnt==WIDTH-1`.
- `busy` = (state==SHIFT).
- `din_ready` = `!hold_full`. At most one word is in flight and one is held, so an accept while `hold_full`=1 cannot occur.
- Reset (async, any time, including mid-word):
  - state → IDLE; `hold_full`, `div_cnt`, `bit_cnt`, `shifter` and `hold` → 0.
  - Outputs: `d`=0, `d_en`=0, `busy`=0, `done`=0, `din_ready`=1.
  - A partially sent word is dropped; nothing resumes after reset release.

## Timing
- Accept from IDLE at edge N: after edge N, `busy`=1 and `d` = first bit.
- First `d_en` falls in cycle N+CLKS_PER_BIT; it is high during the last cycle of the bit period, so `d` is stable around the sampling edge.
- Each bit occupies exactly CLKS_PER_BIT cycles.
- A word occupies WIDTH×CLKS_PER_BIT cycles.
- With `hold_full` at a boundary, the next word's first bit appears right after the boundary edge: zero gap.
- `CLKS_PER_BIT`=1: `d_en` is high every SHIFT cycle.
- `din_ready` falls the cycle after a word is stored in `hold`.
- `din_ready` rises the cycle after `hold` is transferred into `shifter`.
- `done` coincides with the final `d_en` of each word. `busy` drops on the following edge only if no word follows.

## Test plan
- Reset: assert `reset`=0 mid-word (`bit_cnt`=3) → all outputs immediately at reset values, `din_ready`=1; after release, `d` stays 0 and `busy` stays 0.
- Single word: WIDTH=8, CLKS_PER_BIT=4, MSB_FIRST=1, `din`=8'hA5 accepted at edge 0 → `d` = 1,0,1,0,0,1,0,1, each held 4 cycles; `d_en` in cycles 4,8,…,32; `done` in cycle 32; `busy`=0 after it. Downstream `shift_register` ends with q7..q0 = A5 in the order it shifts.
- LSB first: MSB_FIRST=0, `din`=8'h01 → `d`=1 for the first bit period only, then 0 for seven.
- Back-to-back: send 8'hF0 and then 8'h0F while the first is shifting → `din_ready` low until the boundary; 16 bit periods with no gap; two `done` pulses 32 cycles apart.
- Boundary accept with hold empty: present 8'h3C exactly on the boundary cycle of a previous word → loaded directly, no gap, `busy` stays 1.
- CLKS_PER_BIT=1: stream 8'h81 → `d_en` high 8 consecutive cycles, `d` = 1,0,0,0,0,0,0,1.
